// File: rtl/data_ram_sync.sv
// Byte-addressed big-endian data RAM with a fixed-latency request/Ready handshake.
// Requests are latched in IDLE, stretched by WAIT_STATES, and completed in DONE.
module data_ram_sync #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Enable,
  input  logic        RW,
  input  logic [1:0]  Size,
  input  logic        Signed,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Ready,
  output logic        Busy,
  output logic        Fault,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [2:0]    cnt;
  logic [AW-1:0] addr_q;
  logic          rw_q;
  logic [1:0]    size_q;
  logic          sgn_q;
  logic [31:0]   wdata_q;

  logic [7:0]    mem [DEPTH];

  logic [AW-1:0] acc_addr, a1, a2, a3;
  logic          acc_rw;
  logic [1:0]    acc_size;
  logic          acc_sgn;
  logic [31:0]   acc_wdata;
  logic          req_fault;
  logic          do_access;
  logic [31:0]   rd_data;

  // Handshake: Enable is sampled only in IDLE; Ready pulses for exactly one
  // cycle (the DONE cycle) and Fault is meaningful only while Ready is high.
  assign state_dbg = state;

  // With zero wait states the access happens on the accept edge, so the live
  // inputs feed the datapath; otherwise the latched request does.
  always_comb begin
    acc_addr  = addr_q;
    acc_rw    = rw_q;
    acc_size  = size_q;
    acc_sgn   = sgn_q;
    acc_wdata = wdata_q;
    if (state == S_IDLE) begin
      acc_addr  = Address[AW-1:0];
      acc_rw    = RW;
      acc_size  = Size;
      acc_sgn   = Signed;
      acc_wdata = DataIn;
    end
  end

  assign a1 = acc_addr + AW'(1);
  assign a2 = acc_addr + AW'(2);
  assign a3 = acc_addr + AW'(3);

  // Aligned accesses in a power-of-two memory stay in range iff the base does.
  always_comb begin
    req_fault = 1'b0;
    if (Size == 2'b11) req_fault = 1'b1;
    if (Size == 2'b01 && Address[0]) req_fault = 1'b1;
    if (Size == 2'b10 && Address[1:0] != 2'b00) req_fault = 1'b1;
    if (Address >= 32'(DEPTH)) req_fault = 1'b1;
  end

  assign do_access = rst_n &&
    (((state == S_IDLE) && Enable && !req_fault && (WAIT_STATES == 0)) ||
     ((state == S_WAIT) && (cnt == 3'd0)));

  always_comb begin
    rd_data = 32'd0;
    case (acc_size)
      2'b00:   rd_data = {{24{acc_sgn & mem[acc_addr][7]}}, mem[acc_addr]};
      2'b01:   rd_data = {{16{acc_sgn & mem[acc_addr][7]}}, mem[acc_addr], mem[a1]};
      default: rd_data = {mem[acc_addr], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_access && acc_rw) begin
      case (acc_size)
        2'b00: mem[acc_addr] <= acc_wdata[7:0];
        2'b01: begin
          mem[acc_addr] <= acc_wdata[15:8];
          mem[a1]       <= acc_wdata[7:0];
        end
        default: begin
          mem[acc_addr] <= acc_wdata[31:24];
          mem[a1]       <= acc_wdata[23:16];
          mem[a2]       <= acc_wdata[15:8];
          mem[a3]       <= acc_wdata[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 3'd0;
      Ready   <= 1'b0;
      Busy    <= 1'b0;
      Fault   <= 1'b0;
      DataOut <= 32'd0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      if (do_access && !acc_rw) DataOut <= rd_data;
      case (state)
        S_IDLE: begin
          if (Enable) begin
            addr_q  <= Address[AW-1:0];
            rw_q    <= RW;
            size_q  <= Size;
            sgn_q   <= Signed;
            wdata_q <= DataIn;
            Busy    <= 1'b1;
            if (req_fault || WAIT_STATES == 0) begin
              state <= S_DONE;
              Ready <= 1'b1;
              Fault <= req_fault;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) begin
            state <= S_DONE;
            Ready <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          Ready <= 1'b0;
          Fault <= 1'b0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_sync.sv
// Bench for data_ram_sync: three instances (1, 3 and 0 wait states) checked
// against a byte-array reference model with directed and random requests.
module tb_data_ram_sync;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        en    [3];
  logic        rw    [3];
  logic        sgn   [3];
  logic [1:0]  size  [3];
  logic [31:0] addr  [3];
  logic [31:0] din   [3];
  logic [31:0] dout  [3];
  logic        ready [3];
  logic        busy  [3];
  logic        fault [3];
  logic [1:0]  st    [3];

  logic [7:0]  mm [3][DEPTH];
  logic [31:0] exp_dout [3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_ram_sync #(.DEPTH(DEPTH), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst_n(rst_n[0]), .Enable(en[0]), .RW(rw[0]), .Size(size[0]),
    .Signed(sgn[0]), .Address(addr[0]), .DataIn(din[0]), .DataOut(dout[0]),
    .Ready(ready[0]), .Busy(busy[0]), .Fault(fault[0]), .state_dbg(st[0]));

  data_ram_sync #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n[1]), .Enable(en[1]), .RW(rw[1]), .Size(size[1]),
    .Signed(sgn[1]), .Address(addr[1]), .DataIn(din[1]), .DataOut(dout[1]),
    .Ready(ready[1]), .Busy(busy[1]), .Fault(fault[1]), .state_dbg(st[1]));

  data_ram_sync #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n[2]), .Enable(en[2]), .RW(rw[2]), .Size(size[2]),
    .Signed(sgn[2]), .Address(addr[2]), .DataIn(din[2]), .DataOut(dout[2]),
    .Ready(ready[2]), .Busy(busy[2]), .Fault(fault[2]), .state_dbg(st[2]));

  function automatic int ws_of(input int i);
    if (i == 0) return 1;
    if (i == 1) return 3;
    return 0;
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    if (s == 2'b00) return 1;
    if (s == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic model_fault(input logic [1:0] s, input logic [31:0] a);
    longint last;
    if (s == 2'b11) return 1'b1;
    if (a % nbytes(s) != 0) return 1'b1;
    last = longint'(a) + nbytes(s) - 1;
    return last >= DEPTH;
  endfunction

  function automatic logic [31:0] model_read(input int i, input logic [1:0] s,
                                             input logic sg, input logic [31:0] a);
    int nb;
    int idx;
    longint v;
    nb = nbytes(s);
    v = 0;
    for (int b = 0; b < nb; b++) begin
      idx = int'(a) + b;
      v = (v << 8) + longint'(mm[i][idx]);
    end
    // Signed narrow reads: subtract 2^bits to get the two's-complement value.
    if (sg && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic model_write(input int i, input logic [1:0] s, input logic [31:0] a,
                             input logic [31:0] d);
    int nb;
    int idx;
    nb = nbytes(s);
    for (int b = 0; b < nb; b++) begin
      idx = int'(a) + b;
      mm[i][idx] = 8'(d >> (8 * (nb - 1 - b)));
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int i, input string tag);
    check($sformatf("%s d%0d ready", tag, i), 32'(ready[i]), 32'd0);
    check($sformatf("%s d%0d busy", tag, i), 32'(busy[i]), 32'd0);
    check($sformatf("%s d%0d fault", tag, i), 32'(fault[i]), 32'd0);
  endtask

  // Called at #1 after an edge with the DUT idle; returns the same way.
  task automatic do_req(input int i, input logic r, input logic [1:0] s, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
    logic        f;
    int          exp_k;
    logic [31:0] old_dout;
    f = model_fault(s, a);
    exp_k = f ? 0 : ws_of(i);
    old_dout = exp_dout[i];
    if (!f) begin
      if (r) model_write(i, s, a, d);
      else   exp_dout[i] = model_read(i, s, sg, a);
    end
    en[i] = 1'b1; rw[i] = r; size[i] = s; sgn[i] = sg; addr[i] = a; din[i] = d;
    for (int k = 0; k <= exp_k + 1; k++) begin
      @(posedge clk); #1;
      check($sformatf("d%0d a%h k%0d ready", i, a, k), 32'(ready[i]), 32'(k == exp_k));
      check($sformatf("d%0d a%h k%0d fault", i, a, k), 32'(fault[i]), 32'(k == exp_k && f));
      check($sformatf("d%0d a%h k%0d busy", i, a, k), 32'(busy[i]), 32'(k <= exp_k));
      check($sformatf("d%0d a%h k%0d dout", i, a, k), dout[i],
            (k < exp_k) ? old_dout : exp_dout[i]);
      en[i]   = (k <= exp_k) ? 1'($urandom_range(0, 1)) : 1'b0;
      rw[i]   = 1'($urandom_range(0, 1));
      size[i] = 2'($urandom_range(0, 3));
      sgn[i]  = 1'($urandom_range(0, 1));
      addr[i] = $urandom;
      din[i]  = $urandom;
    end
    en[i] = 1'b0;
  endtask

  initial begin
    logic [1:0]  rs;
    logic [31:0] ra;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; en[i] = 1'b0; rw[i] = 1'b0; sgn[i] = 1'b0;
      size[i] = 2'b00; addr[i] = 32'd0; din[i] = 32'd0; exp_dout[i] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_idle(i, "reset");
      check($sformatf("reset d%0d dout", i), dout[i], 32'd0);
      rst_n[i] = 1'b1;
    end

    // Give every byte a known value so reads never see uninitialised storage.
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < DEPTH / 4; w++)
        do_req(i, 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom);

    // One wait state: big-endian layout and extension rules.
    do_req(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    do_req(0, 1'b0, 2'b00, 1'b1, 32'h10, $urandom);
    check("byte_signed_de", dout[0], 32'hFFFFFFDE);
    do_req(0, 1'b0, 2'b01, 1'b0, 32'h12, $urandom);
    check("half_zero_beef", dout[0], 32'h0000BEEF);
    do_req(0, 1'b0, 2'b01, 1'b1, 32'h12, $urandom);
    check("half_sign_beef", dout[0], 32'hFFFFBEEF);

    // Rejected requests leave memory and DataOut alone.
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h11, $urandom);
    do_req(0, 1'b0, 2'b01, 1'b0, 32'h13, $urandom);
    do_req(0, 1'b0, 2'b11, 1'b0, 32'h10, $urandom);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'(DEPTH - 2), $urandom);
    do_req(0, 1'b1, 2'b10, 1'b0, 32'h11, 32'h01020304);
    do_req(0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h01020304);
    do_req(0, 1'b1, 2'b00, 1'b0, 32'(DEPTH), 32'h55);
    do_req(0, 1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h01020304);
    check("fault_keeps_dout", dout[0], 32'hFFFFBEEF);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h10, $urandom);
    check("fault_keeps_mem", dout[0], 32'hDEADBEEF);

    do_req(0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344);
    do_req(0, 1'b1, 2'b00, 1'b0, 32'h31, 32'h000000AA);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h30, $urandom);
    check("byte_merge", dout[0], 32'h11AA3344);
    do_req(0, 1'b1, 2'b10, 1'b0, 32'(DEPTH - 4), 32'h8899AABB);
    do_req(0, 1'b0, 2'b00, 1'b0, 32'(DEPTH - 1), $urandom);
    check("top_byte", dout[0], 32'h000000BB);

    // Three wait states: reset during WAIT abandons the pending write.
    do_req(1, 1'b0, 2'b10, 1'b0, 32'h24, $urandom);
    en[1] = 1'b1; rw[1] = 1'b1; size[1] = 2'b10; sgn[1] = 1'b0;
    addr[1] = 32'h20; din[1] = 32'h12345678;
    @(posedge clk); #1;
    check("abort accept busy", 32'(busy[1]), 32'd1);
    en[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    @(posedge clk); #1;
    check_idle(1, "abort reset");
    check("abort reset dout", dout[1], 32'd0);
    exp_dout[1] = 32'd0;
    rst_n[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_idle(1, $sformatf("abort quiet c%0d", c));
    end
    do_req(1, 1'b0, 2'b10, 1'b0, 32'h20, $urandom);

    // Enable alongside reset is not a request.
    rst_n[1] = 1'b0; en[1] = 1'b1; rw[1] = 1'b0; size[1] = 2'b10; addr[1] = 32'h20;
    @(posedge clk); #1;
    check_idle(1, "en_in_reset");
    check("en_in_reset dout", dout[1], 32'd0);
    exp_dout[1] = 32'd0;
    rst_n[1] = 1'b1; en[1] = 1'b0;
    @(posedge clk); #1;
    check_idle(1, "after_en_reset");

    // Zero wait states, Enable held: one completion every second cycle.
    en[2] = 1'b1; rw[2] = 1'b0; size[2] = 2'b10; sgn[2] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      addr[2] = 32'(n * 4);
      exp_dout[2] = model_read(2, 2'b10, 1'b0, 32'(n * 4));
      @(posedge clk); #1;
      check($sformatf("stream n%0d ready", n), 32'(ready[2]), 32'd1);
      check($sformatf("stream n%0d busy", n), 32'(busy[2]), 32'd1);
      check($sformatf("stream n%0d dout", n), dout[2], exp_dout[2]);
      @(posedge clk); #1;
      check($sformatf("stream n%0d gap ready", n), 32'(ready[2]), 32'd0);
      check($sformatf("stream n%0d gap busy", n), 32'(busy[2]), 32'd0);
    end
    en[2] = 1'b0;

    // Random traffic, biased toward aligned in-range addresses.
    for (int i = 0; i < 3; i++)
      for (int t = 0; t < 60; t++) begin
        rs = 2'($urandom_range(0, 3));
        ra = 32'($urandom_range(0, DEPTH + 40));
        if ($urandom_range(0, 3) != 0) ra = ra & ~32'(nbytes(rs) - 1);
        do_req(i, 1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom);
      end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
